mem_bus_ctrl: RTL and testbench

Memory-side bus controller directly upstream of the 16x256 read/write data RAM. It accepts single read/write requests from the CPU datapath over a req/ready handshake and registers the address and data. It drives the RAM's level-sensitive write port with a glitch-free, one-cycle write pulse. It returns read data with a fixed two-cycle latency and flags accesses outside RAM.

---
 rtl/mem_bus_pkg.sv | 20 ++
 rtl/mem_bus_mmio.sv | 23 ++
 rtl/mem_bus_ctrl.sv | 150 +++++++++++++++
 tb/tb_mem_bus_ctrl.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the memory-side bus controller.
// LED_ADDR / SW_ADDR are only decoded when MEM_BUS_MMIO_EN is defined.
package mem_bus_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_ADDR_W = 8;

    localparam logic [8:0] LED_ADDR = 9'h100;
    localparam logic [8:0] SW_ADDR  = 9'h140;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        RESP,
        WR_SETUP,
        WR_PULSE,
        ERR
    } state_e;

endpackage

// File: rtl/mem_bus_mmio.sv
// LED output register and switch read path for the memory-mapped I/O window.
// Instantiated by mem_bus_ctrl only when MEM_BUS_MMIO_EN is defined.
module mem_bus_mmio (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       led_we,
    input  logic [7:0] led_wdata,
    input  logic [7:0] sw_in,
    output logic [7:0] led_out,
    output logic [7:0] sw_rdata
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led_out <= 8'h00;
        end else if (led_we) begin
            led_out <= led_wdata;
        end
    end

    assign sw_rdata = sw_in;

endmodule

// File: rtl/mem_bus_ctrl.sv
// CPU-to-RAM bus controller: registered address/data, one-cycle write pulse after a setup cycle,
// two-cycle read latency, error pulse for out-of-range accesses. Define MEM_BUS_MMIO_EN for LED/switch I/O.
module mem_bus_ctrl
    import mem_bus_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    // cpu_req/cpu_ready: a request transfers on the rising edge where both are high; the CPU
    // holds cpu_req, cpu_we, cpu_addr and cpu_wdata stable until that edge.
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W:0]   cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ready,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_err,
    output logic [ADDR_W-1:0] ram_read_address,
    output logic [ADDR_W-1:0] ram_write_address,
    output logic              ram_write,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout,
    output logic [CNT_W-1:0]  xact_cnt,
`ifdef MEM_BUS_MMIO_EN
    input  logic [7:0]        sw_in,
    output logic [7:0]        led_out,
`endif
    output state_e            dbg_state
);

    state_e            state;
    logic              accept;
    logic              in_range;
    logic              is_sw;
    logic              is_led;
    logic              rd_go;
    logic              wr_go;
    logic              io_sel;
    logic [DATA_W-1:0] rd_src;

    assign accept    = cpu_req && cpu_ready;
    assign in_range  = !cpu_addr[ADDR_W];
    assign rd_go     = !cpu_we && (in_range || is_sw);
    assign wr_go     = cpu_we && (in_range || is_led);
    assign dbg_state = state;

`ifdef MEM_BUS_MMIO_EN
    logic       io_q;
    logic [7:0] sw_rdata;

    assign is_sw  = (cpu_addr == (ADDR_W+1)'(SW_ADDR));
    assign is_led = (cpu_addr == (ADDR_W+1)'(LED_ADDR));
    assign io_sel = io_q;
    assign rd_src = io_q ? {{(DATA_W-8){1'b0}}, sw_rdata} : ram_dout;

    // Remembers that the access in flight targets I/O rather than the RAM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            io_q <= 1'b0;
        end else if (accept) begin
            io_q <= !in_range;
        end
    end

    mem_bus_mmio u_mmio (
        .clk       (clk),
        .rst_n     (rst_n),
        .led_we    (state == WR_PULSE && io_q),
        .led_wdata (ram_din[7:0]),
        .sw_in     (sw_in),
        .led_out   (led_out),
        .sw_rdata  (sw_rdata)
    );
`else
    assign is_sw  = 1'b0;
    assign is_led = 1'b0;
    assign io_sel = 1'b0;
    assign rd_src = ram_dout;
`endif

    // All outputs are flops; ram_write is the registered decode of "next state is WR_PULSE".
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= IDLE;
            cpu_ready         <= 1'b1;
            cpu_rvalid        <= 1'b0;
            cpu_err           <= 1'b0;
            cpu_rdata         <= '0;
            ram_read_address  <= '0;
            ram_write_address <= '0;
            ram_din           <= '0;
            ram_write         <= 1'b0;
            xact_cnt          <= '0;
        end else begin
            cpu_rvalid <= 1'b0;
            cpu_err    <= 1'b0;
            ram_write  <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        ram_read_address  <= cpu_addr[ADDR_W-1:0];
                        ram_write_address <= cpu_addr[ADDR_W-1:0];
                        ram_din           <= cpu_wdata;
                        cpu_ready         <= 1'b0;
                        if (rd_go) begin
                            state <= RD;
                        end else if (wr_go) begin
                            state <= WR_SETUP;
                        end else begin
                            state   <= ERR;
                            cpu_err <= 1'b1;
                        end
                    end
                end
                RD: begin
                    cpu_rdata  <= rd_src;
                    cpu_rvalid <= 1'b1;
                    state      <= RESP;
                end
                RESP: begin
                    xact_cnt  <= xact_cnt + 1'b1;
                    cpu_ready <= 1'b1;
                    state     <= IDLE;
                end
                WR_SETUP: begin
                    ram_write <= !io_sel;
                    state     <= WR_PULSE;
                end
                WR_PULSE: begin
                    xact_cnt  <= xact_cnt + 1'b1;
                    cpu_ready <= 1'b1;
                    state     <= IDLE;
                end
                ERR: begin
                    cpu_ready <= 1'b1;
                    state     <= IDLE;
                end
                default: begin
                    cpu_ready <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Bench for mem_bus_ctrl: behavioural RAM, reference model of memory contents and counters,
// response/write scoreboards fed by the driver and drained by negedge monitors.
`timescale 1ns/1ps
module tb_mem_bus_ctrl;
    import mem_bus_pkg::*;

    localparam int DW    = 16;
    localparam int AW    = 8;
    localparam int CW    = 4;
    localparam int BOUND = 20;

    // clock / reset
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          cpu_req = 1'b0;
    logic          cpu_we = 1'b0;
    logic [AW:0]   cpu_addr = '0;
    logic [DW-1:0] cpu_wdata = '0;
    logic          cpu_ready, cpu_rvalid, cpu_err, ram_write;
    logic [DW-1:0] cpu_rdata, ram_din, ram_dout;
    logic [AW-1:0] ram_read_address, ram_write_address;
    logic [CW-1:0] xact_cnt;
    state_e        dbg_state;
`ifdef MEM_BUS_MMIO_EN
    logic [7:0]    sw_in = 8'h00;
    logic [7:0]    led_out;
`endif

    mem_bus_ctrl #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(CW)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .cpu_req           (cpu_req),
        .cpu_we            (cpu_we),
        .cpu_addr          (cpu_addr),
        .cpu_wdata         (cpu_wdata),
        .cpu_ready         (cpu_ready),
        .cpu_rvalid        (cpu_rvalid),
        .cpu_rdata         (cpu_rdata),
        .cpu_err           (cpu_err),
        .ram_read_address  (ram_read_address),
        .ram_write_address (ram_write_address),
        .ram_write         (ram_write),
        .ram_din           (ram_din),
        .ram_dout          (ram_dout),
        .xact_cnt          (xact_cnt),
`ifdef MEM_BUS_MMIO_EN
        .sw_in             (sw_in),
        .led_out           (led_out),
`endif
        .dbg_state         (dbg_state)
    );

    // behavioural RAM: combinational read, write committed at the edge that ends the pulse
    logic [DW-1:0] ram_mem [0:255];
    assign ram_dout = ram_mem[ram_read_address];
    always @(posedge clk) if (ram_write) ram_mem[ram_write_address] <= ram_din;

    // reference model state
    logic [DW-1:0] ref_mem [0:255];
    int            ref_cnt = 0;
    int            ref_writes = 0;
    logic [DW-1:0] ref_last = '0;

    // scoreboard
    logic [DW:0]      exp_q[$];   // {is_err, expected cpu_rdata}
    logic [AW+DW-1:0] wr_q[$];    // {address, data} expected on the RAM write port
    int               acc_q[$];   // edge number of each accepted read
    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int rv_seen = 0;
    int err_seen = 0;
    int wr_pulses = 0;
    logic prev_wr = 1'b0;
    logic [DW:0] e;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // response monitor
    always @(negedge clk) begin
        if (cpu_rvalid || cpu_err) begin
            if (cpu_rvalid) rv_seen++;
            if (cpu_err) err_seen++;
            check("resp_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("resp_kind", {cpu_err, cpu_rvalid}, e[DW] ? 2'b10 : 2'b01);
                check("rdata", cpu_rdata, e[DW-1:0]);
                // the CPU samples rvalid at the edge after it rises: accept edge + 2
                if (!e[DW] && acc_q.size() > 0) check("rd_latency_edges", cyc + 1 - acc_q.pop_front(), 2);
            end
        end
    end

    // RAM write-port monitor
    always @(negedge clk) begin
        if (ram_write) begin
            wr_pulses++;
            check("ram_write_width", prev_wr, 0);
            check("write_expected", wr_q.size() > 0, 1);
            if (wr_q.size() > 0) check("write_addr_data", {ram_write_address, ram_din}, wr_q.pop_front());
        end else if (dbg_state == WR_SETUP && wr_q.size() > 0) begin
            check("setup_addr_data", {ram_write_address, ram_din}, wr_q[0]);
        end
        prev_wr = ram_write;
    end

    task automatic model(input bit we, input logic [AW:0] addr, input logic [DW-1:0] d, output bit is_rd);
        is_rd = 1'b0;
        if (addr[AW]) begin
`ifdef MEM_BUS_MMIO_EN
            if (we && addr == LED_ADDR) begin
                ref_cnt++;
                return;
            end
            if (!we && addr == SW_ADDR) begin
                ref_last = {8'h00, sw_in};
                exp_q.push_back({1'b0, ref_last});
                ref_cnt++;
                is_rd = 1'b1;
                return;
            end
`endif
            exp_q.push_back({1'b1, ref_last});
        end else if (we) begin
            ref_mem[addr[AW-1:0]] = d;
            wr_q.push_back({addr[AW-1:0], d});
            ref_writes++;
            ref_cnt++;
        end else begin
            ref_last = ref_mem[addr[AW-1:0]];
            exp_q.push_back({1'b0, ref_last});
            ref_cnt++;
            is_rd = 1'b1;
        end
    endtask

    // driver: called at a negedge; returns at the negedge after the accept edge
    task automatic issue(input bit we, input logic [AW:0] addr, input logic [DW-1:0] d,
                         input bit hold, output int waited);
        int t = 0;
        bit is_rd;
        cpu_req = 1'b1;
        cpu_we = we;
        cpu_addr = addr;
        cpu_wdata = d;
        while (!cpu_ready && t < BOUND) begin
            @(negedge clk);
            t++;
        end
        waited = t;
        if (!cpu_ready) begin
            check("ready_timeout", cpu_ready, 1);
            cpu_req = 1'b0;
            return;
        end
        @(posedge clk);
        model(we, addr, d, is_rd);
        @(negedge clk);
        if (is_rd) acc_q.push_back(cyc);
        if (!hold) cpu_req = 1'b0;
    endtask

    task automatic wait_idle();
        int t = 0;
        while (!cpu_ready && t < BOUND) begin
            @(negedge clk);
            t++;
        end
        if (!cpu_ready) check("idle_timeout", cpu_ready, 1);
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        ref_cnt = 0;
        ref_last = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w, e0, p0, r0;
        logic we;
        logic [AW:0] addr;

        for (int i = 0; i < 256; i++) begin
            ram_mem[i] = DW'($urandom);
            ref_mem[i] = ram_mem[i];
        end
        repeat (2) @(negedge clk);
        check("rst_ready", cpu_ready, 1);
        check("rst_ram_write", ram_write, 0);
        check("rst_rvalid", cpu_rvalid, 0);
        check("rst_err", cpu_err, 0);
        check("rst_xact_cnt", xact_cnt, 0);
        check("rst_rdata", cpu_rdata, 0);
        check("rst_addrs", {ram_read_address, ram_write_address}, 0);
        check("rst_din", ram_din, 0);
        check("rst_state", dbg_state, IDLE);
        rst_n = 1'b1;
        @(negedge clk);

        // write then read
        issue(1'b1, 9'h005, 16'hBEEF, 1'b0, w);
        wait_idle();
        issue(1'b0, 9'h005, 16'h0000, 1'b0, w);
        wait_idle();
        check("wr_rd_rdata", cpu_rdata, 16'hBEEF);
        check("wr_rd_xact_cnt", xact_cnt, 2);

        // reset during WR_PULSE aborts the write
        issue(1'b1, 9'h033, 16'h1234, 1'b0, w);
        wait_idle();
        cpu_req = 1'b1;
        cpu_we = 1'b1;
        cpu_addr = 9'h033;
        cpu_wdata = 16'hDEAD;
        @(posedge clk);
        wr_q.push_back({8'h33, 16'hDEAD});
        ref_writes++;
        @(negedge clk);
        cpu_req = 1'b0;
        @(negedge clk);
        check("pulse_before_reset", ram_write, 1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_async_ram_write", ram_write, 0);
        check("rst_async_xact_cnt", xact_cnt, 0);
        check("rst_async_ready", cpu_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        ref_cnt = 0;
        ref_last = '0;
        check("abort_ram_unchanged", ram_mem[8'h33], 16'h1234);
        issue(1'b0, 9'h033, 16'h0000, 1'b0, w);
        wait_idle();
        check("abort_xact_cnt", xact_cnt, ref_cnt % (1 << CW));

        // out-of-range accesses
        e0 = err_seen;
        p0 = wr_pulses;
        issue(1'b1, 9'h1A5, 16'h5555, 1'b0, w);
        wait_idle();
        issue(1'b0, 9'h1A5, 16'h0000, 1'b0, w);
        wait_idle();
        check("oor_err_pulses", err_seen - e0, 2);
        check("oor_no_write", wr_pulses - p0, 0);
        check("oor_rdata_held", cpu_rdata, ref_last);
        check("oor_xact_cnt", xact_cnt, ref_cnt % (1 << CW));

        // handshake: cpu_req held high across back-to-back reads
        r0 = rv_seen;
        for (int i = 0; i < 8; i++) begin
            issue(1'b0, (i % 2) ? 9'h0FF : 9'h000, 16'h0000, 1'b1, w);
            if (i > 0) check("hs_ready_low_cycles", w, 2);
        end
        cpu_req = 1'b0;
        wait_idle();
        check("hs_rvalid_count", rv_seen - r0, 8);

`ifdef MEM_BUS_MMIO_EN
        p0 = wr_pulses;
        sw_in = 8'h3C;
        issue(1'b1, 9'h100, 16'h00A5, 1'b0, w);
        wait_idle();
        check("mmio_led_out", led_out, 8'hA5);
        issue(1'b0, 9'h140, 16'h0000, 1'b0, w);
        wait_idle();
        check("mmio_sw_rdata", cpu_rdata, 16'h003C);
        check("mmio_no_ram_write", wr_pulses - p0, 0);
`endif

        // randomized traffic
        for (int i = 0; i < 40; i++) begin
            we = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) addr = {1'b1, 8'($urandom)};
            else addr = {1'b0, 8'($urandom_range(0, 15))};
            issue(we, addr, DW'($urandom), 1'b0, w);
            wait_idle();
            check("rand_xact_cnt", xact_cnt, ref_cnt % (1 << CW));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        // counter wrap with a 4-bit counter: 1..15, 0, 1
        pulse_reset();
        for (int i = 0; i < 17; i++) begin
            issue(1'b0, {1'b0, 8'($urandom)}, 16'h0000, 1'b0, w);
            wait_idle();
            check("wrap_xact_cnt", xact_cnt, (i + 1) % 16);
        end

        repeat (3) @(negedge clk);
        check("exp_q_drained", exp_q.size(), 0);
        check("wr_q_drained", wr_q.size(), 0);
        check("write_pulse_total", wr_pulses, ref_writes);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
